// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order commit into the register file, CDB result capture and operand query.
// Optional macro ROB_QUERY_FWD_EN forwards a same-cycle CDB broadcast onto the query port.
module rob_commit_unit #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}},
    parameter int REG_W     = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_reg,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_en,
    output logic [REG_W-1:0]  commit_reg,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    input  logic [TAG_W-1:0]  query_tag,
    output logic              query_ready,
    output logic [DATA_W-1:0] query_data,
    output logic [TAG_W-1:0]  count
);

    localparam int PTR_W = $clog2(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_ready;
    logic [REG_W-1:0]     r_reg  [ROB_DEPTH];
    logic [DATA_W-1:0]    r_data [ROB_DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [TAG_W-1:0]     r_count;

    logic             w_alloc_fire;
    logic             w_commit;
    logic [PTR_W-1:0] w_cdb_idx;
    logic             w_cdb_ok;
    logic             w_cdb_hit;
    logic [PTR_W-1:0] w_q_idx;
    logic             w_q_ok;

    // Tags outside the entry range (including TAG_FREE) never name an entry.
    assign w_cdb_ok  = (cdb_tag < TAG_W'(ROB_DEPTH)) && (cdb_tag != TAG_FREE);
    assign w_q_ok    = (query_tag < TAG_W'(ROB_DEPTH)) && (query_tag != TAG_FREE);
    assign w_cdb_idx = cdb_tag[PTR_W-1:0];
    assign w_q_idx   = query_tag[PTR_W-1:0];
    assign w_cdb_hit = cdb_valid && w_cdb_ok && r_busy[w_cdb_idx] && !r_ready[w_cdb_idx];

    assign alloc_ready  = (r_count != TAG_W'(ROB_DEPTH));
    assign alloc_tag    = TAG_W'(r_tail);
    assign w_alloc_fire = alloc_valid && alloc_ready;

    assign w_commit    = r_busy[r_head] && r_ready[r_head] && !flush;
    assign commit_en   = w_commit;
    assign commit_reg  = r_reg[r_head];
    assign commit_data = r_data[r_head];
    assign commit_tag  = TAG_W'(r_head);
    assign count       = r_count;

    always_comb begin
        query_ready = w_q_ok && r_busy[w_q_idx] && r_ready[w_q_idx];
        query_data  = r_data[w_q_idx];
`ifdef ROB_QUERY_FWD_EN
        if (w_q_ok && r_busy[w_q_idx] && cdb_valid && (cdb_tag == query_tag)) begin
            query_ready = 1'b1;
            query_data  = cdb_data;
        end
`endif
    end

    // Commit, CDB capture and allocation never touch the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_ready[w_cdb_idx] <= 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
            end
            if (w_alloc_fire) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + TAG_W'(w_alloc_fire) - TAG_W'(w_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cdb_hit) begin
            r_data[w_cdb_idx] <= cdb_data;
        end
        if (w_alloc_fire) begin
            r_reg[r_tail] <= alloc_reg;
        end
    end

endmodule
